// File: rtl/avalon_uart.sv
// Avalon-MM 8N1 UART: register file, TX FIFO + serialiser, synchronised RX deserialiser, level IRQ.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, pops the FIFO as soon as it is non-empty
//   TX_START | drives the start bit (0) for BAUD_DIV+1 clk
//   TX_DATA  | drives 8 data bits LSB first, BAUD_DIV+1 clk each
//   TX_STOP  | drives the stop bit (1); chains straight into TX_START if more data is queued
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waits for a 1->0 edge on the synchronised line
//   RX_START | half-bit wait, then confirms the start bit (high = glitch, back to idle)
//   RX_DATA  | samples 8 data bits at mid-bit, LSB first
//   RX_STOP  | samples the stop bit; delivers the byte or flags a framing error
//   RX_WAIT  | after a framing error, waits for the line to return high
module avalon_uart #(
  parameter int unsigned DEFAULT_DIV   = 433,
  parameter int unsigned TX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        irq,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(TX_FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic [15:0]   baud_div;
  logic [1:0]    ctrl;
  logic          rx_valid, rx_overrun, frame_err, tx_drop;
  logic [7:0]    rx_byte;
  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          tx_full, tx_empty, tx_busy, tx_pop, push_ok, push_drop;
  logic          sel_data_wr, sel_stat_wr, sel_baud_wr, sel_ctrl_wr, sel_data_rd;
  logic [6:0]    status;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_txd, txd_n;

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_s3, rx_done, rx_ferr;
  logic [16:0] div_p1;

  assign avs_waitrequest = 1'b0;
  assign uart_txd        = tx_txd;
  assign unused_wdata    = ^avs_writedata[31:16];

  assign sel_data_wr = avs_write && (avs_address == 2'd0);
  assign sel_stat_wr = avs_write && (avs_address == 2'd1);
  assign sel_baud_wr = avs_write && (avs_address == 2'd2);
  assign sel_ctrl_wr = avs_write && (avs_address == 2'd3);
  assign sel_data_rd = avs_read  && (avs_address == 2'd0);

  assign tx_full   = (fifo_count == FIFO_FULL);
  assign tx_empty  = (fifo_count == '0);
  assign tx_busy   = (tx_state != TX_IDLE);
  assign push_ok   = sel_data_wr && !tx_full;
  assign push_drop = sel_data_wr && tx_full;
  assign status    = {tx_drop, frame_err, rx_overrun, tx_busy, tx_empty, tx_full, rx_valid};
  assign div_p1    = {1'b0, baud_div} + 17'd1;

  // Read mux reflects pre-write register values
  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      2'd0:    rd_mux = {24'd0, rx_byte};
      2'd1:    rd_mux = {25'd0, status};
      2'd2:    rd_mux = {16'd0, baud_div};
      default: rd_mux = {30'd0, ctrl};
    endcase
  end

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= avs_writedata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push_ok) - (AW+1)'(tx_pop);
    end
  end

  // Register file, sticky flags, RX holding register, read data and irq
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div     <= DIV_RST;
      ctrl         <= 2'd0;
      tx_drop      <= 1'b0;
      frame_err    <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_valid     <= 1'b0;
      rx_byte      <= 8'd0;
      avs_readdata <= 32'd0;
      irq          <= 1'b0;
    end else begin
      if (avs_read)    avs_readdata <= rd_mux;
      if (sel_baud_wr) baud_div <= (avs_writedata[15:0] < 16'd4) ? 16'd4 : avs_writedata[15:0];
      if (sel_ctrl_wr) ctrl <= avs_writedata[1:0];
      tx_drop    <= (tx_drop    & ~(sel_stat_wr & avs_writedata[6])) | push_drop;
      frame_err  <= (frame_err  & ~(sel_stat_wr & avs_writedata[5])) | rx_ferr;
      rx_overrun <= (rx_overrun & ~(sel_stat_wr & avs_writedata[4])) |
                    (rx_done & rx_valid & ~sel_data_rd);
      if (rx_done && (!rx_valid || sel_data_rd)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (sel_data_rd) begin
        rx_valid <= 1'b0;
      end
      irq <= (rx_valid & ctrl[0]) | (tx_empty & ~tx_busy & ctrl[1]);
    end
  end

  // TX state register; txd is registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_txd   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_txd   <= txd_n;
    end
  end

  // TX next state: down-counter per bit, reloaded from BAUD_DIV at each boundary
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt - 16'd1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = tx_cnt;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr];
          tx_cnt_n   = baud_div;
          tx_state_n = TX_START;
        end
      end
      TX_START: if (tx_cnt == 16'd0) begin
        tx_cnt_n   = baud_div;
        tx_bit_n   = 3'd0;
        tx_state_n = TX_DATA;
      end
      TX_DATA: if (tx_cnt == 16'd0) begin
        tx_cnt_n = baud_div;
        if (tx_bit == 3'd7) begin
          tx_state_n = TX_STOP;
        end else begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
        end
      end
      default: if (tx_cnt == 16'd0) begin
        tx_cnt_n = baud_div;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr];
          tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
    endcase
    case (tx_state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = tx_shift_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  // RX synchroniser plus one extra flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state: half-bit wait to centre the samples, then one sample per bit period
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt - 16'd1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = rx_cnt;
        if (rx_s3 && !rx_s2) begin
          rx_cnt_n   = div_p1[16:1];
          rx_state_n = RX_START;
        end
      end
      RX_START: if (rx_cnt == 16'd0) begin
        rx_cnt_n   = baud_div;
        rx_bit_n   = 3'd0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == 16'd0) begin
        rx_cnt_n   = baud_div;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else                rx_bit_n = rx_bit + 3'd1;
      end
      RX_STOP: if (rx_cnt == 16'd0) begin
        if (rx_s2) begin
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_ferr    = 1'b1;
          rx_state_n = RX_WAIT;
        end
      end
      default: begin
        rx_cnt_n = rx_cnt;
        if (rx_s2) rx_state_n = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_uart.sv
// Directed bench for avalon_uart with 10 clk per bit; uart_txd looped to uart_rxd when loop_en is set.
module tb_avalon_uart;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        irq;
  logic        uart_txd;
  logic        uart_rxd;
  logic        loop_en = 1'b0;
  logic        rxd_drv = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  avalon_uart #(.DEFAULT_DIV(9), .TX_FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .irq             (irq),
    .uart_txd        (uart_txd),
    .uart_rxd        (uart_rxd)
  );

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic wait_status(input logic [31:0] exp, input int budget, output logic [31:0] got);
    got = 32'hx;
    for (int i = 0; i < budget; i++) begin
      bus_read(2'd1, got);
      if (got === exp) break;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rxd_drv = frame[k];
      repeat (9) @(negedge clk);
    end
    @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] got;
    repeat (3) @(negedge clk);
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd got %b want 1", uart_txd); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    vectors++; if (avs_readdata !== 32'd0) begin miscompares++; $display("FAIL reset_readdata got %h want 0", avs_readdata); end
    vectors++; if (avs_waitrequest !== 1'b0) begin miscompares++; $display("FAIL waitrequest got %b want 0", avs_waitrequest); end
    reset = 1'b0;
    bus_read(2'd0, got);
    vectors++; if (got !== 32'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", got); end
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h04) begin miscompares++; $display("FAIL reset_status got %h want 04", got); end
    bus_read(2'd2, got);
    vectors++; if (got !== 32'd9) begin miscompares++; $display("FAIL reset_baud got %h want 9", got); end
    bus_read(2'd3, got);
    vectors++; if (got !== 32'd0) begin miscompares++; $display("FAIL reset_ctrl got %h want 0", got); end
    @(negedge clk);
    avs_address = 2'd3; avs_writedata = 32'h2; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    vectors++; if (avs_readdata !== 32'd0) begin miscompares++; $display("FAIL rw_same_cycle got %h want 0", avs_readdata); end
    bus_read(2'd3, got);
    vectors++; if (got !== 32'd2) begin miscompares++; $display("FAIL ctrl_after_rw got %h want 2", got); end
    bus_write(2'd3, 32'd0);
    bus_write(2'd2, 32'd2);
    bus_read(2'd2, got);
    vectors++; if (got !== 32'd4) begin miscompares++; $display("FAIL baud_clamp got %h want 4", got); end
    bus_write(2'd2, 32'hABC1_1234);
    bus_read(2'd2, got);
    vectors++; if (got !== 32'h1234) begin miscompares++; $display("FAIL baud_rw got %h want 1234", got); end
    bus_write(2'd2, 32'd9);
  endtask

  task automatic test_loopback;
    logic [31:0] got;
    logic [9:0]  frame;
    frame = {1'b1, 8'hA5, 1'b0};
    loop_en = 1'b1;
    bus_write(2'd0, 32'hA5);
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL tx_pre_start got %b want 1", uart_txd); end
    @(negedge clk);
    vectors++; if (uart_txd !== 1'b0) begin miscompares++; $display("FAIL tx_start_edge got %b want 0", uart_txd); end
    repeat (5) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (uart_txd !== frame[k]) begin miscompares++; $display("FAIL tx_bit%0d got %b want %b", k, uart_txd, frame[k]); end
      repeat (10) @(negedge clk);
    end
    wait_status(32'h05, 40, got);
    vectors++; if (got !== 32'h05) begin miscompares++; $display("FAIL loop_rx_valid status got %h want 05", got); end
    bus_read(2'd0, got);
    vectors++; if (got !== 32'hA5) begin miscompares++; $display("FAIL loop_data got %h want a5", got); end
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h04) begin miscompares++; $display("FAIL loop_rx_clear got %h want 04", got); end
  endtask

  task automatic test_fifo_full;
    logic [31:0] got;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      avs_address = 2'd0; avs_writedata = 32'h11 * (i + 1); avs_write = 1'b1;
    end
    @(negedge clk);
    avs_write = 1'b0;
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h0A) begin miscompares++; $display("FAIL fifo_full_status got %h want 0a", got); end
    bus_write(2'd0, 32'h66);
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h4A) begin miscompares++; $display("FAIL tx_drop_status got %h want 4a", got); end
    bus_write(2'd1, 32'h40);
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h0A) begin miscompares++; $display("FAIL tx_drop_w1c got %h want 0a", got); end
    wait_status(32'h04, 400, got);
    vectors++; if (got !== 32'h04) begin miscompares++; $display("FAIL fifo_drain got %h want 04", got); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp_bits, bits;
    logic [31:0] got;
    exp_bits = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h0F, 1'b0};
    bits = 20'd0;
    @(negedge clk);
    avs_address = 2'd0; avs_writedata = 32'h0F; avs_write = 1'b1;
    @(negedge clk);
    avs_writedata = 32'hC3;
    @(negedge clk);
    avs_write = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_txd === 1'b0) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      bits[k] = uart_txd;
      repeat (10) @(negedge clk);
    end
    vectors++; if (bits !== exp_bits) begin miscompares++; $display("FAIL back_to_back_frames got %h want %h", bits, exp_bits); end
    wait_status(32'h04, 100, got);
    vectors++; if (got !== 32'h04) begin miscompares++; $display("FAIL b2b_idle got %h want 04", got); end
  endtask

  task automatic test_rx_errors;
    logic [31:0] got;
    send_rx(8'h3C, 1'b1);
    send_rx(8'h7E, 1'b1);
    repeat (5) @(negedge clk);
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h15) begin miscompares++; $display("FAIL overrun_status got %h want 15", got); end
    bus_read(2'd0, got);
    vectors++; if (got !== 32'h3C) begin miscompares++; $display("FAIL overrun_keeps_old got %h want 3c", got); end
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h14) begin miscompares++; $display("FAIL overrun_after_read got %h want 14", got); end
    send_rx(8'h81, 1'b1);
    send_rx(8'h55, 1'b0);
    repeat (5) @(negedge clk);
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h35) begin miscompares++; $display("FAIL frame_err_status got %h want 35", got); end
    bus_read(2'd0, got);
    vectors++; if (got !== 32'h81) begin miscompares++; $display("FAIL frame_err_discard got %h want 81", got); end
    bus_write(2'd1, 32'h70);
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h04) begin miscompares++; $display("FAIL sticky_w1c got %h want 04", got); end
  endtask

  task automatic test_irq_and_reset;
    logic [31:0] got;
    loop_en = 1'b1;
    bus_write(2'd3, 32'h3);
    @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_tx_idle got %b want 1", irq); end
    bus_write(2'd0, 32'h5A);
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_drop_on_write got %b want 0", irq); end
    for (int i = 0; i < 300; i++) begin
      if (irq === 1'b1) break;
      @(negedge clk);
    end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_after_frame got %b want 1", irq); end
    repeat (10) @(negedge clk);
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h05) begin miscompares++; $display("FAIL irq_status got %h want 05", got); end
    bus_read(2'd0, got);
    vectors++; if (got !== 32'h5A) begin miscompares++; $display("FAIL irq_data got %h want 5a", got); end
    bus_write(2'd0, 32'hF0);
    repeat (25) @(negedge clk);
    vectors++; if (uart_txd !== 1'b0) begin miscompares++; $display("FAIL mid_frame_txd got %b want 0", uart_txd); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL reset_mid_txd got %b want 1", uart_txd); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_mid_irq got %b want 0", irq); end
    vectors++; if (avs_readdata !== 32'd0) begin miscompares++; $display("FAIL reset_mid_readdata got %h want 0", avs_readdata); end
    reset = 1'b0;
    bus_read(2'd0, got);
    vectors++; if (got !== 32'd0) begin miscompares++; $display("FAIL reset_mid_data got %h want 0", got); end
    bus_read(2'd2, got);
    vectors++; if (got !== 32'd9) begin miscompares++; $display("FAIL reset_mid_baud got %h want 9", got); end
    bus_read(2'd3, got);
    vectors++; if (got !== 32'd0) begin miscompares++; $display("FAIL reset_mid_ctrl got %h want 0", got); end
    repeat (150) @(negedge clk);
    bus_read(2'd1, got);
    vectors++; if (got !== 32'h04) begin miscompares++; $display("FAIL reset_mid_status got %h want 04", got); end
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL reset_mid_txd_idle got %b want 1", uart_txd); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_fifo_full();
    test_back_to_back();
    test_rx_errors();
    test_irq_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached after %0d vectors", vectors);
    $fatal(1);
  end

endmodule
